controller_fsm: RTL and testbench

CONTROLLER_FSM -- requirements
Module: controller_fsm

---
 rtl/controller_fsm.sv | 141 ++++++++++++++
 tb/tb_controller_fsm.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/controller_fsm.sv
// Instruction-register decode and Moore control FSM for a simple register/ALU datapath.
// Sequences register reads, ALU execution and writeback for MOV, ADD, CMP, AND and MVN.
module controller_fsm #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             s,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic             w,
  output logic             err,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic [1:0]       vsel,
  output logic             loada,
  output logic             loadb,
  output logic             asel,
  output logic             bsel,
  output logic             loadc,
  output logic             loads,
  output logic             write,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [WIDTH-1:0] sximm5,
  output logic [WIDTH-1:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WIMM, S_GETA, S_GETB, S_EXEC, S_WRD
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             err_q, err_d;

  logic [2:0] opc, rn, rd, rm;
  logic [1:0] op, sh;

  assign opc = ir_q[15:13];
  assign op  = ir_q[12:11];
  assign rn  = ir_q[10:8];
  assign rd  = ir_q[7:5];
  assign sh  = ir_q[4:3];
  assign rm  = ir_q[2:0];

  assign sximm5 = {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]};
  assign sximm8 = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
  assign err    = err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    err_d    = err_q;
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    vsel     = 2'b00;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    write    = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        // A coincident load and start both take effect, so DECODE sees the new word.
        if (load) ir_d = in;
        if (s) begin
          state_d = S_DECODE;
          err_d   = 1'b0;
        end
      end
      S_DECODE: begin
        case ({opc, op})
          5'b110_10:                     state_d = S_WIMM;
          5'b110_00, 5'b101_11:          state_d = S_GETB;
          5'b101_00, 5'b101_01, 5'b101_10: state_d = S_GETA;
          default: begin
            state_d = S_WAIT;
            err_d   = 1'b1;
          end
        endcase
      end
      S_WIMM: begin
        vsel     = 2'b10;
        writenum = rn;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GETB;
      end
      S_GETB: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        shift = sh;
        bsel  = 1'b0;
        ALUop = (opc == 3'b101) ? op : 2'b00;
        // Single-operand forms (MOV reg, MVN) zero the A input.
        asel  = (opc == 3'b110) || (op == 2'b11);
        if (opc == 3'b101 && op == 2'b01) begin
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRD;
        end
      end
      S_WRD: begin
        vsel     = 2'b00;
        writenum = rd;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_controller_fsm.sv
// Scoreboarded random/directed bench for controller_fsm: the driver queues the expected
// per-cycle outputs of each instruction, a negedge monitor pops and compares them.
module tb_controller_fsm;
  logic        clk = 1'b0, resetn = 1'b0, s = 1'b0, load = 1'b0;
  logic [15:0] in = '0;
  logic        w, err, loada, loadb, asel, bsel, loadc, loads, write;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm5, sximm8;

  controller_fsm #(.WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .s(s), .load(load), .in(in),
    .w(w), .err(err), .readnum(readnum), .writenum(writenum), .vsel(vsel),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .loadc(loadc),
    .loads(loads), .write(write), .shift(shift), .ALUop(ALUop),
    .sximm5(sximm5), .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w, err;
    logic [2:0]  rn, wn;
    logic [1:0]  vsel;
    logic        la, lb, as, bs, lc, ls, wr;
    logic [1:0]  sh, alu;
    logic [15:0] sx5, sx8;
  } exp_t;

  exp_t        q[$];
  string       tq[$];
  int          tests = 0, fails = 0;
  logic [15:0] ir_m = '0;
  logic        err_m = 1'b0;

  function automatic exp_t base(logic [15:0] ir);
    exp_t e;
    int   v;
    e = '0;
    v = int'(ir[4:0]);
    if (v > 15) v -= 32;
    e.sx5 = v[15:0];
    v = int'(ir[7:0]);
    if (v > 127) v -= 256;
    e.sx8 = v[15:0];
    return e;
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e = base(16'h0000);
    e.w = 1'b1;
    return e;
  endfunction

  function automatic exp_t act();
    exp_t a;
    a = {w, err, readnum, writenum, vsel, loada, loadb, asel, bsel, loadc, loads,
         write, shift, ALUop, sximm5, sximm8};
    return a;
  endfunction

  task automatic chk(string nm, exp_t a, exp_t e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s @%0t: got w=%b err=%b rn=%0d wn=%0d vsel=%b la=%b lb=%b as=%b bs=%b lc=%b ls=%b wr=%b sh=%b alu=%b sx5=%h sx8=%h | expected w=%b err=%b rn=%0d wn=%0d vsel=%b la=%b lb=%b as=%b bs=%b lc=%b ls=%b wr=%b sh=%b alu=%b sx5=%h sx8=%h",
               nm, $time, a.w, a.err, a.rn, a.wn, a.vsel, a.la, a.lb, a.as, a.bs, a.lc, a.ls,
               a.wr, a.sh, a.alu, a.sx5, a.sx8, e.w, e.err, e.rn, e.wn, e.vsel, e.la, e.lb,
               e.as, e.bs, e.lc, e.ls, e.wr, e.sh, e.alu, e.sx5, e.sx8);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t  e;
      string t;
      e = q.pop_front();
      t = tq.pop_front();
      chk(t, act(), e);
    end
  end

  task automatic do_cycle(exp_t e, string t, logic sv, logic lv, logic [15:0] iv);
    @(posedge clk);
    #2;
    resetn = 1'b1;
    s = sv; load = lv; in = iv;
    q.push_back(e);
    tq.push_back(t);
  endtask

  // mode 0: random inputs while busy; 1: load=1,in=FFFF,s=1 while busy; 2: reset during EXEC
  task automatic phase(exp_t e, string t, int mode);
    if (mode == 1) do_cycle(e, t, 1'b1, 1'b1, 16'hFFFF);
    else           do_cycle(e, t, 1'($urandom), 1'($urandom), 16'($urandom));
  endtask

  task automatic idle();
    exp_t        e;
    logic        lv;
    logic [15:0] iv;
    e = base(ir_m); e.w = 1'b1; e.err = err_m;
    lv = 1'($urandom); iv = 16'($urandom);
    do_cycle(e, "idle", 1'b0, lv, iv);
    if (lv) ir_m = iv;
  endtask

  task automatic run(logic [15:0] word, logic ld, int mode);
    exp_t        e;
    logic [15:0] ir;
    logic [2:0]  opc;
    logic [1:0]  op;
    e = base(ir_m); e.w = 1'b1; e.err = err_m;
    do_cycle(e, "wait_start", 1'b1, ld, word);
    if (ld) ir_m = word;
    err_m = 1'b0;
    ir = ir_m; opc = ir[15:13]; op = ir[12:11];
    phase(base(ir), "decode", mode);
    if (!(opc == 3'b101 || (opc == 3'b110 && (op == 2'b10 || op == 2'b00)))) begin
      err_m = 1'b1;
      return;
    end
    if (opc == 3'b110 && op == 2'b10) begin
      e = base(ir); e.vsel = 2'b10; e.wn = ir[10:8]; e.wr = 1'b1;
      phase(e, "wimm", mode);
      return;
    end
    if (opc == 3'b101 && op != 2'b11) begin
      e = base(ir); e.rn = ir[10:8]; e.la = 1'b1;
      phase(e, "geta", mode);
    end
    e = base(ir); e.rn = ir[2:0]; e.lb = 1'b1;
    phase(e, "getb", mode);
    e = base(ir); e.sh = ir[4:3];
    e.alu = (opc == 3'b101) ? op : 2'b00;
    e.as  = (opc == 3'b110) || (op == 2'b11);
    if (opc == 3'b101 && op == 2'b01) e.ls = 1'b1;
    else                              e.lc = 1'b1;
    phase(e, "exec", mode);
    if (mode == 2) begin
      @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      ir_m = '0; err_m = 1'b0;
      chk("reset_async", act(), rst_exp());
      @(posedge clk);
      #2;
      q.push_back(rst_exp());
      tq.push_back("reset_held");
      return;
    end
    if (opc == 3'b101 && op == 2'b01) return;
    e = base(ir); e.wn = ir[7:5]; e.wr = 1'b1;
    phase(e, "wrd", mode);
  endtask

  initial begin
    #3;
    chk("reset_init", act(), rst_exp());
    run(16'hD0FD, 1'b1, 0);   // MOV R0,#-3
    run(16'hA148, 1'b1, 0);   // ADD R2,R1,R0 LSL
    run(16'hAB04, 1'b1, 0);   // CMP R3,R4
    run(16'hE000, 1'b1, 0);   // illegal
    idle();
    run(16'hC0E1, 1'b1, 0);   // MOV R7,R1 clears err
    run(16'hA148, 1'b1, 1);   // load ignored while busy, s held high
    run(16'h0000, 1'b0, 1);   // immediate restart with unchanged IR
    run(16'hB8A3, 1'b1, 0);   // MVN
    run(16'hA148, 1'b1, 2);   // reset during EXEC
    run(16'hD2F0, 1'b1, 0);   // start right after reset release
    for (int i = 0; i < 60; i++) begin
      logic [15:0] wd;
      int          k;
      wd = 16'($urandom);
      k  = $urandom_range(0, 6);
      case (k)
        0: wd[15:11] = 5'b110_10;
        1: wd[15:11] = 5'b110_00;
        2, 3: wd[15:13] = 3'b101;
        4: wd[15:11] = 5'b101_11;
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) idle();
      run(wd, 1'($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0) ? 1 : 0);
    end
    idle();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
